// File: rtl/load_counter.sv
// Loadable binary up-counter with synchronous reset and terminal-count flag.
// Update priority at each rising edge: reset, then load, then count enable, then hold.
module load_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Reset is applied in the register process so X on load/wdata cannot reach cnt_q.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = wdata;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '1);

endmodule

// File: tb/tb_load_counter.sv
// Directed and randomized checks of load_counter against an arithmetic reference model.
module tb_load_counter;
  localparam int unsigned W   = 5;
  localparam int unsigned MOD = 2 ** W;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic         en;
  logic [W-1:0] wdata;
  logic [W-1:0] cnt;
  logic         tc;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned model       = 0;

  always #5 clk = ~clk;

  load_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .en    (en),
    .wdata (wdata),
    .cnt   (cnt),
    .tc    (tc)
  );

  task automatic check(input string tag, input int unsigned exp);
    logic [W-1:0] exp_cnt;
    logic         exp_tc;
    exp_cnt = exp[W-1:0];
    exp_tc  = (exp == MOD - 1);
    vectors++;
    assert (cnt === exp_cnt) else begin
      miscompares++;
      $error("FAIL %s cnt: got %h expected %h", tag, cnt, exp_cnt);
    end
    vectors++;
    assert (tc === exp_tc) else begin
      miscompares++;
      $error("FAIL %s tc: got %b expected %b", tag, tc, exp_tc);
    end
  endtask

  // Apply inputs, take one rising edge, advance the model, settle outputs.
  task automatic step(input logic r, input logic l, input logic e, input logic [W-1:0] w);
    rst   = r;
    load  = l;
    en    = e;
    wdata = w;
    @(posedge clk);
    if (r)      model = 0;
    else if (l) model = int'(w);
    else if (e) model = (model + 1) % MOD;
    #1;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; wdata = '0;

    step(1'b1, 1'bx, 1'bx, 'x);            check("reset", 32'h00);
    step(1'b0, 1'b1, 1'b0, 5'h1D);         check("load_1d", 32'h1D);
    step(1'b0, 1'b0, 1'b1, 'x);            check("wrap_1e", 32'h1E);
    step(1'b0, 1'b0, 1'b1, 'x);            check("wrap_1f", 32'h1F);
    step(1'b0, 1'b0, 1'b1, 'x);            check("wrap_00", 32'h00);
    step(1'b0, 1'b0, 1'b1, 'x);            check("wrap_01", 32'h01);
    step(1'b0, 1'b0, 1'b1, 'x);            check("wrap_02", 32'h02);
    step(1'b0, 1'b1, 1'b0, 5'h1F);         check("load_ones", 32'h1F);
    step(1'b0, 1'b0, 1'b1, 'x);            check("ones_inc", 32'h00);
    step(1'b0, 1'b1, 1'b1, 5'h1F);         check("load_over_en", 32'h1F);
    step(1'b1, 1'b1, 1'b1, 5'h0A);         check("rst_over_load", 32'h00);
    step(1'b0, 1'b1, 1'b1, 5'h05);         check("load_05", 32'h05);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, $urandom);    check("hold", 32'h05);
    end
    step(1'b0, 1'b1, 1'b0, 5'h11);         check("load_no_en", 32'h11);
    step(1'b0, 1'b1, 1'b1, 5'h11);         check("load_same", 32'h11);
    step(1'b1, 1'b0, 1'b1, 'x);            check("rst_mid_count", 32'h00);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) == 0), ($urandom_range(3) == 0),
           ($urandom_range(3) != 0), W'($urandom));
      check("random", model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_counter.md
Name: load_counter

Overview:
- Synchronous, loadable, free-running binary up-counter; default width 5 bits.
- Used as a general-purpose cycle/event counter inside the CPU datapath and control logic.
- Provides a parallel-load path and a terminal-count flag for wrap detection.

Parameters:
- WIDTH, 5, counter and load-data width in bits (legal range 1..32).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high; highest priority.
- load  input  1  parallel load strobe; when high, the counter takes wdata on the next rising edge.
- en  input  1  count enable; tie high for free-running operation.
- wdata  input  WIDTH  parallel load value.
- cnt  output  WIDTH  current count, registered.
- tc  output  1  terminal count; combinational, high when cnt equals all ones.

Behaviour:
- All state changes occur on the rising edge of clk only. No asynchronous paths.
- Priority at each rising edge is rst, then load, then en, then hold:
  - rst=1: cnt <= 0. load, en and wdata are ignored and may be X.
  - rst=0, load=1: cnt <= wdata. This applies regardless of en.
  - rst=0, load=0, en=1: cnt <= cnt + 1, modulo 2^WIDTH.
  - rst=0, load=0, en=0: cnt holds its value.
- Reset value: cnt = 0, so tc = 0 (for WIDTH > 1).
- Latency: one clock from a sampled control input to the updated cnt. cnt is stable between edges.
- Wrap-around: all ones + 1 becomes 0, with no sticky flag. tc is high during the all-ones cycle only.
- Load of all ones: cnt becomes all ones and tc goes high in the same cycle cnt changes.
- Load of wdata equal to the current cnt: cnt holds; this is not an error.
- Reset mid-count or during load: reset wins and cnt is 0 after that edge.
- X on load or wdata while rst=1 must not propagate into cnt.
- Power-up value before the first reset is undefined. The bench must reset first.
- Pure synchronous RTL with one register bank of WIDTH bits, plus next-state and tc logic. No latches.

Test Plan:
- Reset: drive rst=1 with load and wdata = X for one edge -> cnt = 5'h00, tc = 0.
- Load: rst=0, load=1, wdata=5'h1D -> after one edge, cnt = 5'h1D.
- Count with wrap: from 5'h1D, load=0, en=1 for 5 edges -> cnt sequence 1E, 1F (tc=1), 00, 01, 02; ends at 5'h02.
- Load all ones: load=1, wdata=5'h1F -> cnt = 5'h1F, tc = 1. One more edge with load=0, en=1 -> cnt = 5'h00, tc = 0.
- Reset priority: with cnt = 5'h1F, drive rst=1, load=1, wdata=5'h0A -> cnt = 5'h00 (reset wins over load).
- Hold and load priority:
  - With cnt = 5'h05, en=0 for 3 edges -> cnt stays 5'h05.
  - Then en=0, load=1, wdata=5'h11 -> cnt = 5'h11.
